// File: rtl/full_adder_bist.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_bist
//  Description : Built-in self-test engine for a one-bit full adder cell.
//                Sweeps all eight {a,b,cin} vectors through an external
//                full adder and holds each one for SETTLE_CYCLES before
//                sampling it. It checks sum/cout against the golden function
//                and reports a verdict, a saturating error count and the
//                first failing vector.
//  Revision    : 1.0  initial release
// ============================================================================
module full_adder_bist #(
   parameter int SETTLE_CYCLES = 2,   // 1..15 cycles each vector is held
   parameter int LOOPS         = 1    // 1..255 complete sweeps per run
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       tst_a,
   output logic       tst_b,
   output logic       tst_cin,
   input  logic       dut_sum,
   input  logic       dut_cout,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [2:0] first_fail,
   output logic       first_fail_valid
);

   // Terminal values of the settle and loop counters.
   localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [7:0] c_LOOP_LAST   = 8'(LOOPS - 1);
   localparam logic [2:0] c_IDX_LAST    = 3'd7;
   localparam logic [3:0] c_ERR_MAX     = 4'hF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t     state_q;
   logic [2:0] idx_q;       // current vector {a,b,cin}
   logic [7:0] loop_q;      // completed sweeps in this run
   logic [3:0] settle_q;    // cycles the current vector has been held
   logic [2:0] stim_q;      // registered stimulus driven to the adder
   logic       mism_q;      // sampled mismatch of the held vector
   logic       busy_q;
   logic       done_q;
   logic       pass_q;
   logic [3:0] err_q;
   logic [2:0] ff_q;
   logic       ffv_q;

   logic       exp_sum_d;
   logic       exp_cout_d;
   logic       mism_d;
   logic [3:0] err_inc_d;
   logic [2:0] idx_next_d;

   // Golden full-adder response for the vector currently held, and the
   // mismatch/next-value helpers used by the sequencer.
   always_comb begin
      exp_sum_d  = idx_q[2] ^ idx_q[1] ^ idx_q[0];
      exp_cout_d = (idx_q[2] & idx_q[1]) | (idx_q[2] & idx_q[0]) |
                   (idx_q[1] & idx_q[0]);
      mism_d     = (dut_sum != exp_sum_d) | (dut_cout != exp_cout_d);
      err_inc_d  = (err_q == c_ERR_MAX) ? err_q : err_q + 4'd1;
      idx_next_d = idx_q + 3'd1;
   end

   // Test sequencer: the adder response is sampled on the edge that ends the
   // settle window, so a vector has been held exactly SETTLE_CYCLES cycles
   // when it is judged; the CHECK cycle then books the registered result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= 3'd0;
         loop_q   <= 8'd0;
         settle_q <= 4'd0;
         stim_q   <= 3'd0;
         mism_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= 4'd0;
         ff_q     <= 3'd0;
         ffv_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               stim_q <= 3'd0;
               if (start) begin
                  err_q    <= 4'd0;
                  ff_q     <= 3'd0;
                  ffv_q    <= 1'b0;
                  pass_q   <= 1'b0;
                  busy_q   <= 1'b1;
                  idx_q    <= 3'd0;
                  loop_q   <= 8'd0;
                  settle_q <= 4'd0;
                  state_q  <= APPLY;
               end
            end

            APPLY: begin
               if (settle_q == c_SETTLE_LAST) begin
                  settle_q <= 4'd0;
                  mism_q   <= mism_d;
                  state_q  <= CHECK;
               end else begin
                  settle_q <= settle_q + 4'd1;
               end
            end

            CHECK: begin
               if (mism_q) begin
                  err_q <= err_inc_d;
                  if (!ffv_q) begin
                     ff_q  <= idx_q;
                     ffv_q <= 1'b1;
                  end
               end
               if ((idx_q == c_IDX_LAST) && (loop_q == c_LOOP_LAST)) begin
                  stim_q  <= 3'd0;
                  state_q <= DONE;
               end else begin
                  if (idx_q == c_IDX_LAST) begin
                     loop_q <= loop_q + 8'd1;
                  end
                  idx_q   <= idx_next_d;
                  stim_q  <= idx_next_d;
                  state_q <= APPLY;
               end
            end

            DONE: begin
               // err_q already includes the final CHECK at this point.
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               pass_q  <= (err_q == 4'd0);
               idx_q   <= 3'd0;
               loop_q  <= 8'd0;
               state_q <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign tst_a            = stim_q[2];
   assign tst_b            = stim_q[1];
   assign tst_cin          = stim_q[0];
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign err_count        = err_q;
   assign first_fail       = ff_q;
   assign first_fail_valid = ffv_q;

endmodule
`default_nettype wire

// File: tb/tb_full_adder_bist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_full_adder_bist
//  Description : Self-checking bench for full_adder_bist. Three engines with
//                different parameters each drive a behavioural full adder
//                whose fault mode is selected per run.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_full_adder_bist;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Per-engine signals: 0 = defaults, 1 = LOOPS=3, 2 = SETTLE_CYCLES=1
   logic [2:0]      start_v;
   logic [2:0][2:0] stim_v;
   logic [2:0]      sum_v, cout_v, busy_v, done_v, pass_v, ffv_v;
   logic [2:0][3:0] err_v;
   logic [2:0][2:0] ff_v;
   logic [2:0]      sum_dly;
   int              mode [3];

   int total = 0;
   int bad   = 0;

   // Fault modes: 0 good, 1 sum stuck-0, 2 cout inverted, 3 sum delayed
   // by one register, 4 sum stuck-1, 5 cout stuck-0.
   function automatic logic [1:0] resp(input int m, input logic [2:0] v,
                                       input logic dly);
      logic s, c;
      s = v[2] ^ v[1] ^ v[0];
      c = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
      case (m)
         1: s = 1'b0;
         2: c = ~c;
         3: s = dly;
         4: s = 1'b1;
         5: c = 1'b0;
         default: ;
      endcase
      return {s, c};
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) sum_dly[i] <= ^stim_v[i];
   end

   for (genvar g = 0; g < 3; g++) begin : g_fa
      assign {sum_v[g], cout_v[g]} = resp(mode[g], stim_v[g], sum_dly[g]);
   end

   full_adder_bist u_dut (
      .clk(clk), .rst(rst), .start(start_v[0]),
      .tst_a(stim_v[0][2]), .tst_b(stim_v[0][1]), .tst_cin(stim_v[0][0]),
      .dut_sum(sum_v[0]), .dut_cout(cout_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
      .err_count(err_v[0]), .first_fail(ff_v[0]), .first_fail_valid(ffv_v[0]));

   full_adder_bist #(.LOOPS(3)) u_l3 (
      .clk(clk), .rst(rst), .start(start_v[1]),
      .tst_a(stim_v[1][2]), .tst_b(stim_v[1][1]), .tst_cin(stim_v[1][0]),
      .dut_sum(sum_v[1]), .dut_cout(cout_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
      .err_count(err_v[1]), .first_fail(ff_v[1]), .first_fail_valid(ffv_v[1]));

   full_adder_bist #(.SETTLE_CYCLES(1)) u_s1 (
      .clk(clk), .rst(rst), .start(start_v[2]),
      .tst_a(stim_v[2][2]), .tst_b(stim_v[2][1]), .tst_cin(stim_v[2][0]),
      .dut_sum(sum_v[2]), .dut_cout(cout_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
      .err_count(err_v[2]), .first_fail(ff_v[2]), .first_fail_valid(ffv_v[2]));

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // Wait for done on engine i, counting edges; bounded.
   task automatic wait_done(input int i, output int lat);
      lat = 0;
      while (done_v[i] !== 1'b1 && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // One complete run with start pulsed for a single edge.
   task automatic run(input int i, input int m, input int exp_lat,
                      input bit exp_pass, input logic [3:0] exp_err,
                      input logic [2:0] exp_ff, input bit exp_ffv,
                      input bit chk_stim, input bit mid_start);
      int lat;
      mode[i] = m;
      @(negedge clk); start_v[i] = 1'b1;
      @(posedge clk); #1; start_v[i] = 1'b0;
      chk("busy_on", busy_v[i], 1);
      chk("err_clr", err_v[i], 0);
      chk("ffv_clr", ffv_v[i], 0);
      chk("pass_clr", pass_v[i], 0);
      lat = 0;
      while (done_v[i] !== 1'b1 && lat < 300) begin
         @(posedge clk); #1;
         lat++;
         if (chk_stim && (lat % 3 == 1) && lat < 24)
            chk("stim_step", stim_v[i], (lat - 1) / 3);
         if (mid_start && lat == 10) start_v[i] = 1'b1;
         if (mid_start && lat == 11) start_v[i] = 1'b0;
      end
      chk("latency", lat, exp_lat);
      chk("busy_off", busy_v[i], 0);
      chk("pass", pass_v[i], exp_pass);
      chk("err_count", err_v[i], exp_err);
      chk("first_fail", ff_v[i], exp_ff);
      chk("ff_valid", ffv_v[i], exp_ffv);
      @(posedge clk); #1;
      chk("done_pulse", done_v[i], 0);
   endtask

   typedef struct {
      int         mode;
      bit         exp_pass;
      logic [3:0] exp_err;
      logic [2:0] exp_ff;
      bit         exp_ffv;
   } vec_t;

   vec_t tbl [6];

   initial begin
      int lat;
      bit seen;

      tbl[0] = '{0, 1'b1, 4'd0, 3'b000, 1'b0};  // good adder
      tbl[1] = '{3, 1'b1, 4'd0, 3'b000, 1'b0};  // 1-reg delay, settle 2 ok
      tbl[2] = '{4, 1'b0, 4'd4, 3'b000, 1'b1};  // sum stuck-1: 000,011,101,110
      tbl[3] = '{5, 1'b0, 4'd4, 3'b011, 1'b1};  // cout stuck-0: 011,101,110,111
      tbl[4] = '{2, 1'b0, 4'd8, 3'b000, 1'b1};  // cout inverted: all 8
      tbl[5] = '{1, 1'b0, 4'd4, 3'b001, 1'b1};  // sum stuck-0: 001,010,100,111

      for (int i = 0; i < 3; i++) mode[i] = 0;
      start_v = 3'b000;
      rst = 1'b1;
      #2;
      chk("rst_stim", stim_v[0], 0);
      chk("rst_busy", busy_v[0], 0);
      chk("rst_done", done_v[0], 0);
      chk("rst_pass", pass_v[0], 0);
      chk("rst_err", err_v[0], 0);
      chk("rst_ffv", ffv_v[0], 0);
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;

      // Table of fault modes on the default engine.
      for (int k = 0; k < 6; k++)
         run(0, tbl[k].mode, 25, tbl[k].exp_pass, tbl[k].exp_err,
             tbl[k].exp_ff, tbl[k].exp_ffv, (k == 0), 1'b0);

      // Start pulsed mid-run is ignored; acceptance clears previous errors.
      run(0, 0, 25, 1'b1, 4'd0, 3'b000, 1'b0, 1'b0, 1'b1);

      // start held high: back-to-back runs one IDLE cycle apart.
      mode[0] = 0;
      @(negedge clk); start_v[0] = 1'b1;
      @(posedge clk); #1;
      wait_done(0, lat);
      chk("b2b_lat1", lat, 25);
      chk("b2b_busy_gap", busy_v[0], 0);
      @(posedge clk); #1;
      chk("b2b_busy_again", busy_v[0], 1);
      start_v[0] = 1'b0;
      wait_done(0, lat);
      chk("b2b_lat2", lat, 25);
      chk("b2b_pass", pass_v[0], 1);

      // LOOPS=3 with cout inverted: 24 mismatches saturate at 15.
      run(1, 2, 73, 1'b0, 4'd15, 3'b000, 1'b1, 1'b0, 1'b0);

      // SETTLE_CYCLES=1 with delayed sum sees the previous vector's sum:
      // mismatches at 001,011,100,101,111.
      run(2, 3, 17, 1'b0, 4'd5, 3'b001, 1'b1, 1'b0, 1'b0);
      run(2, 0, 17, 1'b1, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0);

      // Reset during the 5th vector.
      mode[0] = 0;
      @(negedge clk); start_v[0] = 1'b1;
      @(posedge clk); #1; start_v[0] = 1'b0;
      repeat (13) @(posedge clk);
      #1;
      chk("mid_vec4", stim_v[0], 4);
      rst = 1'b1;
      #1;
      chk("mr_stim", stim_v[0], 0);
      chk("mr_busy", busy_v[0], 0);
      chk("mr_pass", pass_v[0], 0);
      chk("mr_done", done_v[0], 0);
      chk("mr_err", err_v[0], 0);
      chk("mr_ffv", ffv_v[0], 0);
      @(negedge clk); rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) seen = 1'b1;
      end
      chk("mr_no_resume", seen, 0);
      run(0, 0, 25, 1'b1, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
